// File: rtl/gate_sequencer.sv
// gate_sequencer: arm -> trigger -> delay -> gated PMT pulse count -> held result.
// Latency: gate opens delay+1 cycles after trig_pos; result lands one cycle after the last gate cycle.
// Backpressure: result/overflow/result_valid held in HOLD until result_ready; arm and trig_pos ignored meanwhile.
//
// Ports: clk/rst_n (async assert, synchronised release); arm, abort, trig_pos, pmt_pos strobes;
//        delay/gate_len window setup (captured on trigger); gate, busy status;
//        result/overflow/result_valid with result_ready handshake.
module gate_sequencer #(
    parameter int CNT_W = 32,
    parameter int DLY_W = 16,
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic             trig_pos,
    input  logic             pmt_pos,
    input  logic [DLY_W-1:0] delay,
    input  logic [LEN_W-1:0] gate_len,
    output logic             gate,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_GATE,
        S_HOLD
    } state_t;

    state_t           state;
    logic [1:0]       rst_sync;
    logic             run_en;
    logic [DLY_W-1:0] dly_cnt;
    logic [LEN_W-1:0] len_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_sat;
    logic             sat_nxt;
    logic             hit;
    logic             open_now;
    logic [LEN_W-1:0] open_len;

    // Reset asserts asynchronously everywhere, but the FSM only starts moving
    // once the release has passed through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run_en = rst_sync[1];

    // Saturating pulse count; sat_nxt records that an increment was lost.
    assign hit = gate & pmt_pos;

    always_comb begin
        cnt_nxt = cnt;
        sat_nxt = cnt_sat;
        if (hit) begin
            if (cnt == '1) begin
                sat_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // The window opens either straight from the trigger (zero delay) or on the
    // last delay cycle. len_cnt already holds the captured length in DELAY.
    assign open_now = (state == S_ARMED && trig_pos && delay == '0) ||
                      (state == S_DELAY && dly_cnt == DLY_W'(1));
    assign open_len = (state == S_ARMED) ? gate_len : len_cnt;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            gate         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            dly_cnt      <= '0;
            len_cnt      <= '0;
            cnt          <= '0;
            cnt_sat      <= 1'b0;
        end else if (run_en) begin
            if (abort) begin
                state        <= S_IDLE;
                gate         <= 1'b0;
                result_valid <= 1'b0;
                dly_cnt      <= '0;
                len_cnt      <= '0;
                cnt          <= '0;
                cnt_sat      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm) begin
                            state <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (trig_pos) begin
                            cnt     <= '0;
                            cnt_sat <= 1'b0;
                            dly_cnt <= delay;
                            len_cnt <= gate_len;
                            state   <= S_DELAY;
                        end
                    end
                    S_DELAY: begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                    S_GATE: begin
                        cnt     <= cnt_nxt;
                        cnt_sat <= sat_nxt;
                        if (len_cnt == LEN_W'(1)) begin
                            gate         <= 1'b0;
                            state        <= S_HOLD;
                            result       <= cnt_nxt;
                            overflow     <= sat_nxt;
                            result_valid <= 1'b1;
                        end else begin
                            len_cnt <= len_cnt - LEN_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (result_ready) begin
                            state        <= S_IDLE;
                            result_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase

                // Overrides the DELAY transition above when the window opens now.
                // A zero-length window reports an empty result instead of gating.
                if (open_now) begin
                    if (open_len == '0) begin
                        state        <= S_HOLD;
                        result       <= '0;
                        overflow     <= 1'b0;
                        result_valid <= 1'b1;
                    end else begin
                        state <= S_GATE;
                        gate  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
